// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM state codes,
// a debug view of the states, and default counter/gate widths.
package clk_freq_meter_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int GATE_W_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } fm_state_e;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Measurement request/result bundle of the frequency meter.
// master: gate_len/start/target/tol out, busy/valid/count/overflow/in_range in.
interface clk_freq_meter_if
    import clk_freq_meter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
);
    logic [GATE_W-1:0] gate_len;
    logic              start;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  tol;
    logic              busy;
    logic              valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              in_range;

    modport master (
        output gate_len, start, target, tol,
        input  busy, valid, count, overflow, in_range
    );

    modport slave (
        input  gate_len, start, target, tol,
        output busy, valid, count, overflow, in_range
    );
endinterface

// File: rtl/clk_freq_meter_sync.sv
// Synchronizes meas_clk into the reference domain and flags rising edges.
// Ports: clk_i, rst_i (sync, active-high), async_i, edge_o (1-cycle pulse).
module clk_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    assign sync_d = {sync_q[STAGES-2:0], async_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/clk_freq_meter.sv
// Counts meas_clk rising edges over a gate of clk_in cycles and flags the
// result against target +/- tol. Ports: clk_in, rst, meas_clk, bus (slave).
// FREQ_METER_CONT_EN: back-to-back windows while start stays high.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            meas_clk,
    clk_freq_meter_if.slave bus
);
    logic              edge_w;
    logic [1:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  tol_q, tol_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovfo_q, ovfo_d;
    logic              inr_q, inr_d;

    logic [CNT_W-1:0]  acc;
    logic              acc_ovf;
    logic [CNT_W:0]    diff;
    logic [CNT_W:0]    mag;
    logic              cmp_ok;
    logic              go;

    clk_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_in),
        .rst_i   (rst),
        .async_i (meas_clk),
        .edge_o  (edge_w)
    );

    // An edge arriving while the counter is full is lost: that is overflow.
    assign acc_ovf = ovf_q | (edge_w & (&cnt_q));
    assign acc     = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, edge_w};

    // One extra bit keeps the difference from wrapping.
    assign diff   = {1'b0, acc} - {1'b0, tgt_q};
    assign mag    = diff[CNT_W] ? (~diff + 1'b1) : diff;
    assign cmp_ok = !acc_ovf && (mag <= {1'b0, tol_q});

    assign go = bus.start && (bus.gate_len != '0);

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tgt_d   = tgt_q;
        tol_d   = tol_q;
        valid_d = 1'b0;
        count_d = count_q;
        ovfo_d  = ovfo_q;
        inr_d   = inr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_COUNT;
                    gate_d  = bus.gate_len;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tgt_d   = bus.target;
                    tol_d   = bus.tol;
                end
            end
            ST_COUNT: begin
                cnt_d  = acc;
                ovf_d  = acc_ovf;
                gate_d = gate_q - {{(GATE_W-1){1'b0}}, 1'b1};
                // Results are registered on the way into DONE so that
                // valid and the new values appear in the same cycle.
                if (gate_q == {{(GATE_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    count_d = acc;
                    ovfo_d  = acc_ovf;
                    inr_d   = cmp_ok;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef FREQ_METER_CONT_EN
                if (go) begin
                    state_d = ST_COUNT;
                    gate_d  = bus.gate_len;
                    cnt_d   = {{(CNT_W-1){1'b0}}, edge_w};
                    ovf_d   = 1'b0;
                    tgt_d   = bus.target;
                    tol_d   = bus.tol;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tgt_q   <= '0;
            tol_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            ovfo_q  <= 1'b0;
            inr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tgt_q   <= tgt_d;
            tol_q   <= tol_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ovfo_q  <= ovfo_d;
            inr_q   <= inr_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.valid    = valid_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovfo_q;
    assign bus.in_range = inr_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed and randomized checks of clk_freq_meter against an
// edge-rate model derived from the clock periods.
module tb_clk_freq_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic meas16 = 1'b0;
    logic meas4 = 1'b0;
    int   half_ns = 20;
    int   checks = 0;
    int   errors = 0;

`ifdef FREQ_METER_CONT_EN
    localparam int HELD_PER = 51;
`else
    localparam int HELD_PER = 52;
`endif

    clk_freq_meter_if #(.CNT_W(16), .GATE_W(16)) bus16 ();
    clk_freq_meter_if #(.CNT_W(4), .GATE_W(16)) bus4 ();

    clk_freq_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) u16 (
        .clk_in   (clk),
        .rst      (rst),
        .meas_clk (meas16),
        .bus      (bus16.slave)
    );

    clk_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(3)) u4 (
        .clk_in   (clk),
        .rst      (rst),
        .meas_clk (meas4),
        .bus      (bus4.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #3;
        forever #(half_ns) meas16 = ~meas16;
    end

    initial begin
        #3;
        forever #10 meas4 = ~meas4;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int got,
                           input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // Lat counts cycles from the accepting edge's cycle (t) to valid.
    task automatic measure(input int g, input int tgt, input int tl,
                           output int lat, output int cnt,
                           output int ov, output int ir);
        @(posedge clk); #1;
        bus16.gate_len = 16'(g);
        bus16.target   = 16'(tgt);
        bus16.tol      = 16'(tl);
        bus16.start    = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        chk("busy_after_start", int'(bus16.busy), 1);
        lat = 1;
        while (!bus16.valid && lat < g + 50) begin
            @(posedge clk); #1;
            lat++;
        end
        cnt = int'(bus16.count);
        ov  = int'(bus16.overflow);
        ir  = int'(bus16.in_range);
        @(posedge clk); #1;
        chk("valid_one_cycle", int'(bus16.valid), 0);
        chk("busy_after_done", int'(bus16.busy), 0);
    endtask

    initial begin
        int lat, cnt, ov, ir, n, first, per, seen;
        int g, num, den, lo, hi, nom, tl, tgt, exp_ir;

        bus16.start = 1'b0; bus16.gate_len = '0;
        bus16.target = '0;  bus16.tol = '0;
        bus4.start = 1'b0;  bus4.gate_len = '0;
        bus4.target = '0;   bus4.tol = '0;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus16.busy), 0);
        chk("rst_valid", int'(bus16.valid), 0);
        chk("rst_count", int'(bus16.count), 0);
        chk("rst_ovf", int'(bus16.overflow), 0);
        chk("rst_inr", int'(bus16.in_range), 0);
        chk("rst4_count", int'(bus4.count), 0);
        rst = 1'b0;

        // meas = clk/4, 100-cycle gate: 25 edges expected
        half_ns = 20;
        repeat (10) @(posedge clk);
        measure(100, 25, 1, lat, cnt, ov, ir);
        chk("div4_latency", lat, 101);
        chk_rng("div4_count", cnt, 24, 25);
        chk("div4_inr", ir, 1);
        chk("div4_ovf", ov, 0);

        // meas = clk/8, 64-cycle gate: 8 edges, far from target
        half_ns = 40;
        repeat (20) @(posedge clk);
        measure(64, 25, 2, lat, cnt, ov, ir);
        chk("div8_latency", lat, 65);
        chk_rng("div8_count", cnt, 7, 9);
        chk("div8_inr", ir, 0);
        chk("div8_ovf", ov, 0);

        // 4-bit counter, meas = clk/2: 50 edges saturate at 15
        @(posedge clk); #1;
        bus4.gate_len = 16'd100;
        bus4.target = 4'd15;
        bus4.tol = 4'd0;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        n = 1;
        while (!bus4.valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sat_latency", n, 101);
        chk("sat_count", int'(bus4.count), 15);
        chk("sat_ovf", int'(bus4.overflow), 1);
        chk("sat_inr", int'(bus4.in_range), 0);

        // zero gate length is ignored
        @(posedge clk); #1;
        bus16.gate_len = '0;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        seen = 0;
        repeat (20) begin
            if (bus16.busy || bus16.valid) seen++;
            @(posedge clk); #1;
        end
        chk("gate0_quiet", seen, 0);

        // start while busy does not restart or stretch the window
        half_ns = 20;
        @(posedge clk); #1;
        bus16.gate_len = 16'd40;
        bus16.target = 16'd10;
        bus16.tol = 16'd1;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        n = 1;
        repeat (10) begin
            @(posedge clk); #1;
            n++;
        end
        bus16.gate_len = 16'd200;
        bus16.target = 16'd0;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        n++;
        bus16.start = 1'b0;
        while (!bus16.valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart_latency", n, 41);
        chk_rng("restart_count", int'(bus16.count), 9, 10);
        chk("restart_inr", int'(bus16.in_range), 1);
        repeat (3) @(posedge clk);

        // reset 30 cycles into a 100-cycle window
        @(posedge clk); #1;
        bus16.gate_len = 16'd100;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(bus16.busy), 0);
        chk("abort_count", int'(bus16.count), 0);
        chk("abort_valid", int'(bus16.valid), 0);
        seen = 0;
        repeat (110) begin
            @(posedge clk); #1;
            if (bus16.valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        measure(100, 25, 1, lat, cnt, ov, ir);
        chk("after_abort_latency", lat, 101);
        chk_rng("after_abort_count", cnt, 24, 25);
        chk("after_abort_inr", ir, 1);

        // start held high: periodic results
        @(posedge clk); #1;
        bus16.gate_len = 16'd50;
        bus16.start = 1'b1;
        n = 0; first = -1; per = -1;
        while (n < 400 && per < 0) begin
            @(posedge clk); #1;
            n++;
            if (bus16.valid) begin
                if (first < 0) first = n;
                else per = n - first;
            end
        end
        bus16.start = 1'b0;
        chk("held_period", per, HELD_PER);
        repeat (60) @(posedge clk);

        // random meas periods against a rate model
        for (int r = 0; r < 6; r++) begin
            half_ns = int'($urandom_range(11, 50));
            repeat (20) @(posedge clk);
            g   = int'($urandom_range(20, 200));
            num = g * 10;
            den = 2 * half_ns;
            nom = num / den;
            lo  = nom - 1;
            hi  = (num + den - 1) / den + 1;
            tl  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                tgt = nom;
                tl = tl + 3;
                exp_ir = 1;
            end else begin
                tgt = nom + tl + 5;
                exp_ir = 0;
            end
            measure(g, tgt, tl, lat, cnt, ov, ir);
            chk("rnd_latency", lat, g + 1);
            chk_rng("rnd_count", cnt, lo, hi);
            chk("rnd_inr", ir, exp_ir);
            chk("rnd_ovf", ov, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
